code_entry_unit: RTL and testbench

Digit-capture and code-comparison responder for the lock controller. It accumulates keypad digits while the controller asserts read_input, and reports length validity back to it. On each command key it commits the entry and answers the controller's compareType request with correct_input/data_ready. It also holds the user code (UC) and the pending new UC, and writes the pending code into the UC on the controller's store pulse.

---
 rtl/code_entry_unit.sv | 182 ++++++++++++++++++
 tb/tb_code_entry_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_unit.sv
`default_nettype none
// ============================================================================
// Module      : code_entry_unit
// Description : Keypad digit capture and code comparison for the lock
//               controller. Collects digits while read_input is high, commits
//               on command keys, compares against PC / UC / pending UC, and
//               holds the user code with a store path for the pending code.
// Revision    : 1.0 - initial release
// ============================================================================
module code_entry_unit #(
    parameter int                   MAX_LEN        = 8,
    parameter int                   MIN_LEN        = 4,
    parameter int                   PC_LEN         = 6,
    parameter logic [4*MAX_LEN-1:0] PC_CODE        = 'h135246,
    parameter logic [4*MAX_LEN-1:0] DEFAULT_UC     = 'h1234,
    parameter int                   DEFAULT_UC_LEN = 4
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic [3:0] button,
    input  logic       bstate,
    input  logic       read_input,
    input  logic [1:0] compareType,
    input  logic       store,
    output logic       validLength,
    output logic       validLengthPC,
    output logic       correct_input,
    output logic       data_ready,
    output logic [3:0] digit_count,
    output logic       overflow
);

    localparam int         BW          = 4 * MAX_LEN;
    localparam logic [3:0] c_max_len   = 4'(MAX_LEN);
    localparam logic [3:0] c_min_len   = 4'(MIN_LEN);
    localparam logic [3:0] c_pc_len    = 4'(PC_LEN);
    localparam logic [3:0] c_uc_len    = 4'(DEFAULT_UC_LEN);
    localparam logic [1:0] c_cmp_store = 2'd3;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_next_state;
    logic          r_prev_bstate;
    logic [BW-1:0] r_buf;
    logic [3:0]    r_count;
    logic          r_ovf;
    logic [BW-1:0] r_snap;
    logic [3:0]    r_snap_len;
    logic          r_snap_ovf;
    logic [BW-1:0] r_pend;
    logic [3:0]    r_pend_len;
    logic [BW-1:0] r_uc;
    logic [3:0]    r_uc_len;
    logic          r_data_ready;

    logic w_rel;
    logic w_is_cmd;
    logic w_active;
    logic w_digit;
    logic w_commit;
    logic w_cancel;
    logic w_correct;

    // Key event: a release is a held key that has just been let go
    assign w_rel    = r_prev_bstate & ~bstate;
    assign w_is_cmd = (button == 4'd7) || (button == 4'd8) || (button == 4'd9);

    // FSM state register
    always_ff @(posedge hwclk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // FSM next state: capture follows read_input, a falling read_input ends the entry
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (read_input)  w_next_state = S_COLLECT;
            S_COLLECT: if (!read_input) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: key actions only count while collecting and read_input is still high
    always_comb begin
        w_active = 1'b0;
        w_digit  = 1'b0;
        w_commit = 1'b0;
        w_cancel = 1'b0;
        if (r_state == S_COLLECT && read_input) begin
            w_active = 1'b1;
            w_digit  = w_rel && !w_is_cmd;
            w_commit = w_rel && (button == 4'd8 || button == 4'd9);
            w_cancel = w_rel && (button == 4'd7);
        end
    end

    // Key history and the one-cycle data_ready pulse following a commit
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            r_prev_bstate <= 1'b0;
            r_data_ready  <= 1'b0;
        end else begin
            r_prev_bstate <= bstate;
            r_data_ready  <= w_commit;
        end
    end

    // Live entry buffer: shift digits in, flag overflow, clear on commit/cancel/idle
    always_ff @(posedge hwclk) begin
        if (!rst_n || !w_active || w_commit || w_cancel) begin
            r_buf   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_digit) begin
            if (r_count < c_max_len) begin
                r_buf   <= {r_buf[BW-5:0], button};
                r_count <= r_count + 4'd1;
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Committed snapshot of the entry used by the comparator
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            r_snap     <= '0;
            r_snap_len <= '0;
            r_snap_ovf <= 1'b0;
        end else if (w_commit) begin
            r_snap     <= r_buf;
            r_snap_len <= r_count;
            r_snap_ovf <= r_ovf;
        end
    end

    // User code and pending code; a commit that captures a new pending code
    // overrides the clear from a simultaneous store, which used the old value
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            r_uc       <= DEFAULT_UC;
            r_uc_len   <= c_uc_len;
            r_pend     <= '0;
            r_pend_len <= '0;
        end else begin
            if (store && r_pend_len != 4'd0) begin
                r_uc       <= r_pend;
                r_uc_len   <= r_pend_len;
                r_pend     <= '0;
                r_pend_len <= '0;
            end
            if (w_commit && compareType == c_cmp_store) begin
                r_pend     <= r_buf;
                r_pend_len <= r_count;
            end
        end
    end

    // Comparator: snapshot against the reference chosen by compareType
    always_comb begin
        w_correct = 1'b0;
        case (compareType)
            2'd0:    w_correct = (r_snap == PC_CODE) && (r_snap_len == c_pc_len);
            2'd1:    w_correct = (r_snap == r_uc)    && (r_snap_len == r_uc_len);
            2'd2:    w_correct = (r_snap == r_pend)  && (r_snap_len == r_pend_len);
            default: w_correct = 1'b0;
        endcase
        if (r_snap_ovf) w_correct = 1'b0;
    end

    assign correct_input = w_correct;
    assign data_ready    = r_data_ready;
    assign digit_count   = r_count;
    assign overflow      = r_ovf;
    assign validLength   = !r_ovf && (r_count >= c_min_len) && (r_count <= c_max_len);
    assign validLengthPC = !r_ovf && (r_count == c_pc_len);

endmodule
`default_nettype wire

// File: tb/tb_code_entry_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_entry_unit
// Description : Self-checking bench for code_entry_unit. Digit sequences are
//               modelled as queues; outputs are checked every cycle plus a
//               set of literal expectations along a directed sequence,
//               followed by randomized key traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_entry_unit;

    logic       hwclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] button = 4'd0;
    logic       bstate = 1'b0;
    logic       read_input = 1'b0;
    logic [1:0] compareType = 2'd1;
    logic       store = 1'b0;
    logic       validLength;
    logic       validLengthPC;
    logic       correct_input;
    logic       data_ready;
    logic [3:0] digit_count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    code_entry_unit dut (
        .hwclk        (hwclk),
        .rst_n        (rst_n),
        .button       (button),
        .bstate       (bstate),
        .read_input   (read_input),
        .compareType  (compareType),
        .store        (store),
        .validLength  (validLength),
        .validLengthPC(validLengthPC),
        .correct_input(correct_input),
        .data_ready   (data_ready),
        .digit_count  (digit_count),
        .overflow     (overflow)
    );

    always #5 hwclk = ~hwclk;

    // ---------------- behavioural model: entries as digit queues -------------
    int  live[$];
    int  snap[$];
    int  pend[$];
    int  uc[$];
    int  pcq[$];
    bit  m_ovf, m_snap_ovf, m_collect, m_prev_b, m_dr;
    bit  chk_en = 1'b0;

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge hwclk) begin
        bit rel;
        bit dr_next;
        int k;
        if (!rst_n) begin
            live.delete(); snap.delete(); pend.delete();
            uc = '{1, 2, 3, 4};
            m_ovf = 0; m_snap_ovf = 0; m_collect = 0; m_prev_b = 0; m_dr = 0;
            chk_en = 1'b1;
        end else begin
            rel = m_prev_b && !bstate;
            k = int'(button);
            dr_next = 0;
            if (store && pend.size() != 0) begin
                uc = pend;
                pend.delete();
            end
            if (m_collect && read_input) begin
                if (rel && k != 7 && k != 8 && k != 9) begin
                    if (live.size() < 8) live.push_back(k);
                    else m_ovf = 1;
                end else if (rel && (k == 8 || k == 9)) begin
                    snap = live;
                    m_snap_ovf = m_ovf;
                    if (compareType == 2'd3) pend = live;
                    live.delete(); m_ovf = 0;
                    dr_next = 1;
                end else if (rel && k == 7) begin
                    live.delete(); m_ovf = 0;
                end
            end else begin
                live.delete(); m_ovf = 0;
            end
            m_collect = read_input;
            m_prev_b  = bstate;
            m_dr      = dr_next;
        end
    end

    function automatic bit exp_correct();
        if (m_snap_ovf) return 1'b0;
        case (compareType)
            2'd0:    return same_q(snap, pcq);
            2'd1:    return same_q(snap, uc);
            2'd2:    return same_q(snap, pend);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge hwclk) begin
        if (chk_en) begin
            check("validLength", 32'(validLength),
                  32'(!m_ovf && live.size() >= 4 && live.size() <= 8));
            check("validLengthPC", 32'(validLengthPC), 32'(!m_ovf && live.size() == 6));
            check("digit_count", 32'(digit_count), 32'(live.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("data_ready", 32'(data_ready), 32'(m_dr));
            check("correct_input", 32'(correct_input), 32'(exp_correct()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge hwclk);
        #2;
    endtask

    task automatic press(input logic [3:0] k);
        button = k;
        bstate = 1'b1;
        step();
        bstate = 1'b0;
        step();
    endtask

    task automatic enter(input int d[$]);
        foreach (d[i]) press(4'(d[i]));
    endtask

    task automatic pulse_store();
        store = 1'b1;
        step();
        store = 1'b0;
    endtask

    initial begin
        pcq = '{1, 3, 5, 2, 4, 6};
        step(); step();
        rst_n = 1'b1;
        check("reset_count", 32'(digit_count), 32'd0);
        check("reset_dr", 32'(data_ready), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);

        // basic UC match with default user code
        read_input = 1'b1; compareType = 2'd1;
        step();
        enter('{1, 2, 3, 4});
        check("vl_before_cmd", 32'(validLength), 32'd1);
        check("count_4", 32'(digit_count), 32'd4);
        press(4'd9);
        check("dr_pulse", 32'(data_ready), 32'd1);
        check("uc_match", 32'(correct_input), 32'd1);
        step();
        check("dr_single", 32'(data_ready), 32'd0);

        // programming code
        compareType = 2'd0;
        enter('{1, 3, 5, 2, 4, 6});
        check("vlpc_6", 32'(validLengthPC), 32'd1);
        press(4'd8);
        check("pc_match", 32'(correct_input), 32'd1);
        enter('{1, 3, 5});
        check("vlpc_3", 32'(validLengthPC), 32'd0);
        press(4'd8);
        check("pc_short", 32'(correct_input), 32'd0);

        // new UC: store pending, match it, commit it
        compareType = 2'd3;
        enter('{5, 5, 6, 6, 8});
        compareType = 2'd2;
        enter('{5, 5, 6, 6, 8});
        check("pend_match", 32'(correct_input), 32'd1);
        pulse_store();
        compareType = 2'd1;
        enter('{5, 5, 6, 6, 8});
        check("new_uc_match", 32'(correct_input), 32'd1);
        enter('{1, 2, 3, 4, 8});
        check("old_uc_fail", 32'(correct_input), 32'd0);

        // overflow
        enter('{1, 2, 3, 4, 5, 6, 0, 1, 2});
        check("ovf_count", 32'(digit_count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_vl", 32'(validLength), 32'd0);
        press(4'd9);
        check("ovf_commit", 32'(correct_input), 32'd0);

        // cancel keeps the previous snapshot
        enter('{5, 5, 6, 6, 8});
        enter('{1, 2, 7});
        check("cancel_count", 32'(digit_count), 32'd0);
        check("cancel_no_dr", 32'(data_ready), 32'd0);
        check("cancel_snap", 32'(correct_input), 32'd1);

        // reset mid-entry restores default UC and drops pending
        compareType = 2'd3;
        enter('{2, 4, 6, 0, 8});
        enter('{1, 2, 3});
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_count", 32'(digit_count), 32'd0);
        step();
        pulse_store();
        compareType = 2'd1;
        enter('{2, 4, 6, 0, 8});
        check("rst_pend_gone", 32'(correct_input), 32'd0);
        enter('{1, 2, 3, 4, 9});
        check("rst_uc_default", 32'(correct_input), 32'd1);

        // randomized traffic
        for (int it = 0; it < 800; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst_n = 1'b0; step(); rst_n = 1'b1;
            end else if (r < 7) begin
                pulse_store();
            end else if (r < 11) begin
                read_input = 1'b0; step(); read_input = 1'b1; step();
            end else if (r < 14) begin
                button = 4'($urandom_range(0, 15));
                bstate = 1'b1; step();
                bstate = 1'b0; read_input = 1'b0; step();
                read_input = 1'b1; step();
            end else if (r < 17) begin
                step();
            end else begin
                if ($urandom_range(0, 3) == 0) compareType = 2'($urandom_range(0, 3));
                press(4'($urandom_range(0, 15)));
            end
        end
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
